// File: rtl/calc_pkg.sv
// Shared key/operator codes, controller states and key classification helpers.
package calc_pkg;

    localparam int unsigned KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_EQ  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_CLR = 4'hB;
    localparam logic [KEY_W-1:0] OP_ADD  = 4'hC;
    localparam logic [KEY_W-1:0] OP_SUB  = 4'hD;
    localparam logic [KEY_W-1:0] OP_MUL  = 4'hE;
    localparam logic [KEY_W-1:0] OP_DIV  = 4'hF;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        CAPTURE,
        SHOW_RES,
        ERR
    } state_t;

    // Source selected for the next display value.
    typedef enum logic [2:0] {
        DSP_KEEP,
        DSP_A,
        DSP_B,
        DSP_ZERO,
        DSP_RES
    } disp_src_t;

    function automatic logic is_digit(input logic [KEY_W-1:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [KEY_W-1:0] k);
        return k >= OP_ADD;
    endfunction

endpackage

// File: rtl/calc_controller_entry_reg.sv
// BCD operand entry register: digit shift-in with saturation, fresh start, parallel load, clear.
module bcd_entry_reg #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  ld,
    input  logic [4*DIGITS-1:0]   ld_data,
    input  logic                  shift,
    input  logic                  fresh,
    input  logic [3:0]            digit,
    output logic [4*DIGITS-1:0]   value,
    output logic [4*DIGITS-1:0]   nxt_c
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Next value: clear beats load beats shift; shifting stops once all digits are used.
    always_comb begin
        nxt_c   = value;
        cnt_nxt = cnt;
        if (clr) begin
            nxt_c   = '0;
            cnt_nxt = '0;
        end else if (ld) begin
            nxt_c   = ld_data;
            cnt_nxt = CW'(DIGITS);
        end else if (shift && fresh) begin
            nxt_c   = W'(digit);
            cnt_nxt = CW'(1);
        end else if (shift && (cnt < CW'(DIGITS))) begin
            nxt_c   = {value[W-5:0], digit};
            cnt_nxt = cnt + CW'(1);
        end
    end

    // Operand and digit-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            cnt   <= '0;
        end else begin
            value <= nxt_c;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Keypad sequencer for the BCD calculator ALU: operand entry, operator latch, exe pulse, result capture.
module calc_controller
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned EXE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [4*DIGITS-1:0]   res,
    output logic [4*DIGITS-1:0]   num1,
    output logic [4*DIGITS-1:0]   num2,
    output logic [3:0]            op,
    output logic                  exe,
    output logic [4*DIGITS-1:0]   display,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned W   = 4 * DIGITS;
    localparam int unsigned EXW = (EXE_CYCLES > 1) ? $clog2(EXE_CYCLES) : 1;

    state_t          state, state_n;
    logic [3:0]      op_n;
    logic [3:0]      pend, pend_n;
    logic            pend_v, pend_v_n;
    logic            b_seen, b_seen_n;
    logic            err_n;
    logic [EXW-1:0]  cnt, cnt_n;
    disp_src_t       dsel;
    logic [W-1:0]    display_n;

    logic            a_clr, a_ld, a_shift, a_fresh;
    logic            b_clr, b_shift;
    logic [W-1:0]    num1_nxt, num2_nxt;

    logic            key_act;
    logic            go_exec;
    logic            div_zero;
    logic            sub_neg;

    bcd_entry_reg #(.DIGITS(DIGITS)) u_num1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (a_clr),
        .ld      (a_ld),
        .ld_data (res),
        .shift   (a_shift),
        .fresh   (a_fresh),
        .digit   (key_code),
        .value   (num1),
        .nxt_c   (num1_nxt)
    );

    bcd_entry_reg #(.DIGITS(DIGITS)) u_num2 (
        .clk     (clk),
        .rst     (rst),
        .clr     (b_clr),
        .ld      (1'b0),
        .ld_data ('0),
        .shift   (b_shift),
        .fresh   (1'b0),
        .digit   (key_code),
        .value   (num2),
        .nxt_c   (num2_nxt)
    );

    // Next state, operand controls and error/display decisions from key events.
    always_comb begin
        state_n  = state;
        op_n     = op;
        pend_n   = pend;
        pend_v_n = pend_v;
        b_seen_n = b_seen;
        err_n    = err;
        cnt_n    = cnt;
        dsel     = DSP_KEEP;
        a_clr    = 1'b0;
        a_ld     = 1'b0;
        a_shift  = 1'b0;
        a_fresh  = 1'b0;
        b_clr    = 1'b0;
        b_shift  = 1'b0;
        go_exec  = 1'b0;

        key_act  = key_valid && (state != EXEC) && (state != CAPTURE);
        div_zero = (op == OP_DIV) && (num2 == '0);
        sub_neg  = (op == OP_SUB) && (num1 < num2);

        if (key_act && (key_code == KEY_CLR)) begin
            a_clr    = 1'b1;
            b_clr    = 1'b1;
            state_n  = ENTER_A;
            op_n     = OP_ADD;
            pend_n   = OP_ADD;
            pend_v_n = 1'b0;
            b_seen_n = 1'b0;
            err_n    = 1'b0;
            dsel     = DSP_ZERO;
        end else begin
            case (state)
                ENTER_A: begin
                    if (key_act && is_digit(key_code)) begin
                        a_shift = 1'b1;
                        dsel    = DSP_A;
                    end else if (key_act && is_op(key_code)) begin
                        op_n     = key_code;
                        b_clr    = 1'b1;
                        b_seen_n = 1'b0;
                        state_n  = ENTER_B;
                        dsel     = DSP_ZERO;
                    end
                end
                ENTER_B: begin
                    if (key_act && is_digit(key_code)) begin
                        b_shift  = 1'b1;
                        b_seen_n = 1'b1;
                        dsel     = DSP_B;
                    end else if (key_act && is_op(key_code) && !b_seen) begin
                        op_n = key_code;
                    end else if (key_act && is_op(key_code)) begin
                        pend_n   = key_code;
                        pend_v_n = 1'b1;
                        go_exec  = 1'b1;
                    end else if (key_act && (key_code == KEY_EQ)) begin
                        pend_v_n = 1'b0;
                        go_exec  = 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == EXW'(EXE_CYCLES - 1)) begin
                        state_n = CAPTURE;
                    end else begin
                        cnt_n = cnt + EXW'(1);
                    end
                end
                CAPTURE: begin
                    a_ld = 1'b1;
                    dsel = DSP_RES;
                    if (pend_v) begin
                        op_n     = pend;
                        b_clr    = 1'b1;
                        b_seen_n = 1'b0;
                        pend_v_n = 1'b0;
                        state_n  = ENTER_B;
                    end else begin
                        state_n = SHOW_RES;
                    end
                end
                SHOW_RES: begin
                    if (key_act && is_digit(key_code)) begin
                        a_shift = 1'b1;
                        a_fresh = 1'b1;
                        dsel    = DSP_A;
                        state_n = ENTER_A;
                    end else if (key_act && is_op(key_code)) begin
                        op_n     = key_code;
                        b_clr    = 1'b1;
                        b_seen_n = 1'b0;
                        state_n  = ENTER_B;
                        dsel     = DSP_ZERO;
                    end else if (key_act && (key_code == KEY_EQ)) begin
                        pend_v_n = 1'b0;
                        go_exec  = 1'b1;
                    end
                end
                default: ;
            endcase

            if (go_exec) begin
                if (div_zero) begin
                    err_n    = 1'b1;
                    dsel     = DSP_ZERO;
                    pend_v_n = 1'b0;
                    state_n  = ERR;
                end else if (sub_neg) begin
                    err_n    = 1'b1;
                    pend_v_n = 1'b0;
                    state_n  = ERR;
                end else begin
                    cnt_n   = '0;
                    state_n = EXEC;
                end
            end
        end
    end

    // Display source mux; kept apart so operand next-values do not feed back into the FSM block.
    always_comb begin
        display_n = display;
        case (dsel)
            DSP_A:    display_n = num1_nxt;
            DSP_B:    display_n = num2_nxt;
            DSP_ZERO: display_n = '0;
            DSP_RES:  display_n = res;
            default:  display_n = display;
        endcase
    end

    // State and registered outputs; exe/busy follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ENTER_A;
            op      <= OP_ADD;
            pend    <= OP_ADD;
            pend_v  <= 1'b0;
            b_seen  <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            display <= '0;
            exe     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            op      <= op_n;
            pend    <= pend_n;
            pend_v  <= pend_v_n;
            b_seen  <= b_seen_n;
            err     <= err_n;
            cnt     <= cnt_n;
            display <= display_n;
            exe     <= (state_n == EXEC);
            busy    <= (state_n == EXEC) || (state_n == CAPTURE);
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Self-checking bench: directed scenarios plus random key streams against a decimal calculator model.
module tb_calc_controller;
    import calc_pkg::*;

    localparam int unsigned EXE_CYCLES = 1;
    localparam int unsigned GAP        = EXE_CYCLES + 3;

    localparam int M_A   = 0;
    localparam int M_B   = 1;
    localparam int M_RES = 2;
    localparam int M_ERR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [15:0] res = 16'h0;
    logic [15:0] num1, num2, display;
    logic [3:0]  op;
    logic        exe, err, busy;

    int checks   = 0;
    int failures = 0;

    // Bench-side ALU and exe monitor state.
    int          pulses  = 0;
    int          run_len = 0;
    logic        exe_prev = 1'b0;
    logic [15:0] alu_a = 16'h0;
    logic [15:0] alu_b = 16'h0;

    // Decimal calculator model.
    int         m_a, m_b, m_na, m_nb, m_disp, m_mode, m_pulses;
    logic [3:0] m_op;
    logic       m_bseen, m_err;

    calc_controller #(.DIGITS(4), .EXE_CYCLES(EXE_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .res       (res),
        .num1      (num1),
        .num2      (num2),
        .op        (op),
        .exe       (exe),
        .display   (display),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] x);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic int alu_dec(input int a, input int b, input logic [3:0] o);
        case (o)
            OP_ADD:  return (a + b) % 10000;
            OP_SUB:  return (a >= b) ? a - b : 0;
            OP_MUL:  return (a * b) % 10000;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ALU stand-in and exe pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (exe && !exe_prev) begin
            pulses++;
            alu_a = num1;
            alu_b = num2;
            res   = to_bcd(alu_dec(from_bcd(num1), from_bcd(num2), op));
        end
        if (exe) begin
            run_len++;
        end else begin
            if (run_len != 0) check("exe_width", 16'(run_len), 16'(EXE_CYCLES));
            run_len = 0;
        end
        exe_prev = exe;
    end

    task automatic model_reset();
        m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_disp = 0;
        m_mode = M_A; m_op = OP_ADD; m_bseen = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_exec(input logic has_pend, input logic [3:0] pend);
        if (m_op == OP_DIV && m_b == 0) begin
            m_err = 1'b1; m_disp = 0; m_mode = M_ERR;
        end else if (m_op == OP_SUB && m_a < m_b) begin
            m_err = 1'b1; m_mode = M_ERR;
        end else begin
            m_pulses++;
            m_a    = alu_dec(m_a, m_b, m_op);
            m_na   = 4;
            m_disp = m_a;
            if (has_pend) begin
                m_op = pend; m_b = 0; m_nb = 0; m_bseen = 1'b0; m_mode = M_B;
            end else begin
                m_mode = M_RES;
            end
        end
    endtask

    task automatic model_key(input logic [3:0] k);
        if (k == KEY_CLR) begin
            model_reset();
        end else if (m_mode == M_ERR) begin
            // locked until clear
        end else if (k <= 4'd9) begin
            if (m_mode == M_A) begin
                if (m_na < 4) begin m_a = m_a * 10 + int'(k); m_na++; end
                m_disp = m_a;
            end else if (m_mode == M_B) begin
                if (m_nb < 4) begin m_b = m_b * 10 + int'(k); m_nb++; end
                m_bseen = 1'b1;
                m_disp  = m_b;
            end else begin
                m_a = int'(k); m_na = 1; m_mode = M_A; m_disp = m_a;
            end
        end else if (k >= OP_ADD) begin
            if (m_mode == M_B) begin
                if (!m_bseen) m_op = k;
                else model_exec(1'b1, k);
            end else begin
                m_op = k; m_b = 0; m_nb = 0; m_bseen = 1'b0; m_mode = M_B; m_disp = 0;
            end
        end else begin
            if (m_mode != M_A) model_exec(1'b0, 4'h0);
        end
    endtask

    task automatic drive(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic send_key(input logic [3:0] k);
        model_key(k);
        drive(k);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_seq(input logic [3:0] ks[$]);
        foreach (ks[i]) send_key(ks[i]);
    endtask

    task automatic verify(input string tag);
        check({tag, ".num1"},    num1,         to_bcd(m_a));
        check({tag, ".num2"},    num2,         to_bcd(m_b));
        check({tag, ".op"},      16'(op),      16'(m_op));
        check({tag, ".display"}, display,      to_bcd(m_disp));
        check({tag, ".err"},     16'(err),     16'(m_err));
        check({tag, ".busy"},    16'(busy),    16'h0);
        check({tag, ".pulses"},  16'(pulses),  16'(m_pulses));
    endtask

    initial begin
        int r;
        logic [3:0] k;
        m_pulses = 0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.exe", 16'(exe), 16'h0);
        check("rst.op",  16'(op),  16'(OP_ADD));
        rst = 1'b0;
        verify("reset");

        // 12 + 34
        send_seq('{4'h1, 4'h2, OP_ADD, 4'h3, 4'h4, KEY_EQ});
        check("add.display", display, 16'h0046);
        verify("add");

        // Digit saturation
        send_seq('{KEY_CLR, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9});
        check("sat.num1", num1, 16'h9999);
        verify("sat");

        // Divide by zero locks until clear
        send_seq('{KEY_CLR, 4'h5, OP_DIV, 4'h0, KEY_EQ});
        check("div0.err", 16'(err), 16'h1);
        check("div0.display", display, 16'h0000);
        verify("div0");
        send_seq('{4'h3, OP_ADD, KEY_EQ});
        check("div0.locked", 16'(err), 16'h1);
        verify("div0_locked");
        send_key(KEY_CLR);
        check("div0.cleared", 16'(err), 16'h0);
        verify("div0_clr");

        // Negative subtraction
        send_seq('{4'h3, OP_SUB, 4'h7, KEY_EQ});
        check("subneg.err", 16'(err), 16'h1);
        verify("subneg");

        // Chaining and repeat-equals
        send_seq('{KEY_CLR, 4'h2, OP_ADD, 4'h3, OP_MUL});
        check("chain1.display", display, 16'h0005);
        check("chain1.op", 16'(op), 16'(OP_MUL));
        verify("chain1");
        send_seq('{4'h4, KEY_EQ});
        check("chain2.display", display, 16'h0020);
        verify("chain2");
        send_key(KEY_EQ);
        check("repeat.alu_a", alu_a, 16'h0020);
        check("repeat.alu_b", alu_b, 16'h0004);
        verify("repeat");

        // Digit while busy is discarded
        send_seq('{KEY_CLR, 4'h1, OP_ADD, 4'h2});
        model_key(KEY_EQ);
        drive(KEY_EQ);
        check("busy.busy", 16'(busy), 16'h1);
        check("busy.exe",  16'(exe),  16'h1);
        drive(4'h7);
        repeat (GAP) @(negedge clk);
        check("busy.display", display, 16'h0003);
        verify("busy");

        // Reset in the middle of an execution
        send_seq('{KEY_CLR, 4'h1, OP_ADD, 4'h2});
        model_key(KEY_EQ);
        drive(KEY_EQ);
        check("rstexec.exe_before", 16'(exe), 16'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstexec.exe", 16'(exe), 16'h0);
        model_reset();
        verify("rstexec");
        send_key(4'h5);
        check("rstexec.enter_a", num1, 16'h0005);
        verify("rstexec_a");

        // Random key stream
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      k = 4'($urandom_range(0, 9));
            else if (r < 80) k = 4'($urandom_range(12, 15));
            else if (r < 93) k = KEY_EQ;
            else             k = KEY_CLR;
            send_key(k);
            verify("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
